// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - 12-channel time-multiplexed tone scheduler with saturating mixer
// Define NOTE_SAW_EN to add the sawtooth waveform mode toggled by modekey.
module note_scheduler #(
   parameter int unsigned SAMPLE_DIV = 256,
   parameter logic [7:0]  AMP        = 8'd64
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic [11:0] keys,
   input  logic        modekey,
   output logic [7:0]  sample_out,
   output logic        sample_valid,
   output logic [11:0] active,
   output logic        mode,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] tick_cnt;
   logic        tick;
   logic [3:0]  ch;
   logic [15:0] count [12];
   logic [11:0] level;
   logic [11:0] acc;

   logic [15:0] div_cur;
   logic [16:0] sum;
   logic        wrap;
   logic [15:0] count_nxt;
   logic        level_nxt;
   logic [7:0]  value;
   logic [11:0] acc_nxt;
   logic [7:0]  sample_sat;

   function automatic logic [15:0] div_of(input logic [3:0] idx);
      case (idx)
         4'd0:    div_of = 16'd38223;
         4'd1:    div_of = 16'd36077;
         4'd2:    div_of = 16'd34052;
         4'd3:    div_of = 16'd32141;
         4'd4:    div_of = 16'd30337;
         4'd5:    div_of = 16'd28635;
         4'd6:    div_of = 16'd27027;
         4'd7:    div_of = 16'd25511;
         4'd8:    div_of = 16'd24079;
         4'd9:    div_of = 16'd22727;
         4'd10:   div_of = 16'd21452;
         default: div_of = 16'd20248;
      endcase
   endfunction

   assign tick = (tick_cnt == 16'(SAMPLE_DIV - 1));
   assign busy = (state == SCAN);

   // Shared per-channel datapath; the result is never wider than 16 bits, so the
   // subtraction can safely be done modulo 2^16.
   always_comb begin
      div_cur   = div_of(ch);
      sum       = {1'b0, count[ch]} + 17'(SAMPLE_DIV);
      wrap      = (sum >= {1'b0, div_cur});
      count_nxt = wrap ? (sum[15:0] - div_cur) : sum[15:0];
      level_nxt = level[ch] ^ wrap;
`ifdef NOTE_SAW_EN
      if (mode)
         value = {2'b00, count[ch][15:10]};
      else
         value = level_nxt ? AMP : 8'd0;
`else
      value = level_nxt ? AMP : 8'd0;
`endif
      if (!active[ch])
         value = 8'd0;
      acc_nxt    = acc + {4'd0, value};
      sample_sat = (acc_nxt > 12'd255) ? 8'hFF : acc_nxt[7:0];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = SCAN;
         SCAN:    if (ch == 4'd11) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         ch           <= '0;
         level        <= '0;
         acc          <= '0;
         active       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
         for (int i = 0; i < 12; i++)
            count[i] <= '0;
      end else begin
         state        <= state_nxt;
         tick_cnt     <= tick ? 16'd0 : tick_cnt + 16'd1;
         sample_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (tick) begin
                  active <= keys;
                  acc    <= '0;
                  ch     <= '0;
               end
            end
            SCAN: begin
               // A released note is parked at phase 0 so a re-press starts clean.
               if (active[ch]) begin
                  count[ch] <= count_nxt;
                  level[ch] <= level_nxt;
               end else begin
                  count[ch] <= '0;
                  level[ch] <= 1'b0;
               end
               acc <= acc_nxt;
               ch  <= ch + 4'd1;
               if (ch == 4'd11) begin
                  sample_out   <= sample_sat;
                  sample_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef NOTE_SAW_EN
   logic pend;

   // Pending flag counts modekey pulses mod 2; a pulse on the tick cycle belongs to the next period.
   always_ff @(posedge clk or posedge n_rst) begin
      if (n_rst) begin
         mode <= 1'b0;
         pend <= 1'b0;
      end else if (state == IDLE && tick) begin
         mode <= mode ^ pend;
         pend <= modekey;
      end else if (modekey) begin
         pend <= ~pend;
      end
   end
`else
   logic unused_modekey;
   assign unused_modekey = modekey;
   assign mode           = 1'b0;
`endif

endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - scoreboard bench for note_scheduler
`timescale 1ns/1ps
module tb_note_scheduler;

   logic        clk = 1'b0;
   logic        n_rst;
   logic [11:0] keys;
   logic        modekey;
   logic [7:0]  sample_out;
   logic        sample_valid;
   logic [11:0] active;
   logic        mode;
   logic        busy;

   int    compared   = 0;
   int    mismatched = 0;
   int    strobe_no  = 0;
   int    exp_q[$];
   string aux_name[$];
   int    aux_act[$];
   int    aux_exp[$];

   always #50 clk = ~clk;

   note_scheduler #(.SAMPLE_DIV(256), .AMP(8'd64)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .keys         (keys),
      .modekey      (modekey),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .active       (active),
      .mode         (mode),
      .busy         (busy)
   );

   // Toggle ticks for C, C#, D, D# starting from phase 0 with an increment of 256.
   function automatic int exp_four(input int n);
      int cnt;
      int v;
      cnt = 0;
      if (n >= 150 && n < 299) cnt++;
      if (n >= 141 && n < 282) cnt++;
      if (n >= 134 && n < 267) cnt++;
      if (n >= 126 && n < 252) cnt++;
      v = 64 * cnt;
      return (v > 255) ? 255 : v;
   endfunction

   task automatic expect_now(input string name, input int act, input int exp_v);
      aux_name.push_back(name);
      aux_act.push_back(act);
      aux_exp.push_back(exp_v);
   endtask

   // Monitor: the only process that counts comparisons.
   always @(negedge clk) begin
      while (aux_name.size() > 0) begin
         string nm;
         int    a;
         int    e;
         nm = aux_name.pop_front();
         a  = aux_act.pop_front();
         e  = aux_exp.pop_front();
         compared++;
         if (a != e) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
         end
      end
      if (sample_valid) begin
         strobe_no++;
         compared++;
         if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL strobe_unexpected #%0d: got sample %0d, expected no strobe", strobe_no, sample_out);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(sample_out) != e) begin
               mismatched++;
               $display("FAIL sample_out strobe #%0d: got %0d, expected %0d", strobe_no, sample_out, e);
            end
         end
      end
   end

   task automatic wait_busy();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = busy;
      end
      if (!seen) expect_now("busy_timeout", 0, 1);
   endtask

   task automatic wait_strobe();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         seen = sample_valid;
      end
      if (!seen) expect_now("strobe_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic [11:0] k, input int e);
      keys = k;
      exp_q.push_back(e);
      wait_strobe();
   endtask

   task automatic step_busy(input logic [11:0] k_old, input logic [11:0] k_new, input int e);
      exp_q.push_back(e);
      wait_busy();
      keys = k_new;
      @(negedge clk);
      expect_now("active_hold_during_busy", int'(active), int'(k_old));
      wait_strobe();
   endtask

   task automatic pulse_mode();
      @(negedge clk);
      modekey = 1'b1;
      @(negedge clk);
      modekey = 1'b0;
   endtask

   initial begin
      #(120000 * 100);
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      n_rst   = 1'b1;
      keys    = 12'h000;
      modekey = 1'b0;
      repeat (3) @(negedge clk);
      expect_now("reset_sample_out", int'(sample_out), 0);
      expect_now("reset_sample_valid", int'(sample_valid), 0);
      expect_now("reset_active", int'(active), 0);
      expect_now("reset_mode", int'(mode), 0);
      expect_now("reset_busy", int'(busy), 0);

      // Abort the first scan at T+5.
      keys  = 12'h00F;
      n_rst = 1'b0;
      wait_busy();
      expect_now("active_snapshot", int'(active), 15);
      repeat (4) @(negedge clk);
      n_rst = 1'b1;
      #1;
      expect_now("midscan_reset_active", int'(active), 0);
      expect_now("midscan_reset_busy", int'(busy), 0);
      expect_now("midscan_reset_valid", int'(sample_valid), 0);
      expect_now("midscan_reset_sample", int'(sample_out), 0);
      repeat (2) @(negedge clk);

      exp_q.push_back(0);
      n_rst = 1'b0;
      lat   = 0;
      for (int i = 1; i <= 400 && lat == 0; i++) begin
         @(posedge clk);
         #1;
         if (sample_valid) lat = i;
      end
      expect_now("first_strobe_latency", lat, 268);
      @(posedge clk);
      #1;

      // Four notes: levels rise one by one, all four high saturates.
      for (int n = 2; n <= 152; n++)
         step(12'h00F, exp_four(n));
      step(12'h007, 192);
      step_busy(12'h007, 12'h000, 192);
      step(12'h000, 0);
      expect_now("active_after_release", int'(active), 0);

      // Re-pressed C restarts from phase 0.
      for (int j = 1; j <= 151; j++)
         step(12'h001, (j >= 150) ? 64 : 0);

`ifdef NOTE_SAW_EN
      step(12'h000, 0);
      pulse_mode();
      for (int j = 1; j <= 8; j++)
         step(12'h001, (j - 1) / 4);
      expect_now("mode_after_one_pulse", int'(mode), 1);
      pulse_mode();
      pulse_mode();
      step(12'h001, 2);
      expect_now("mode_after_two_pulses", int'(mode), 1);
`else
      pulse_mode();
      step(12'h001, 64);
      expect_now("mode_tied_low", int'(mode), 0);
`endif

      repeat (3) @(negedge clk);
      expect_now("pending_strobes", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/note_scheduler.md
# note_scheduler

Time-multiplexed tone scheduler that sits between the keypad front end and the signal mixer/PWM back end of the synthesizer. Once per sample period it walks the 12 note channels through one shared phase-update datapath. For each channel it advances a 16-bit phase counter against that note's frequency divider and generates the channel's waveform value. It then sums and saturates the enabled channels into one 8-bit sample and strobes it to the PWM stage.

## Interface
- `SAMPLE_DIV`, 256: clocks per sample period; also the per-tick phase increment; must be < 20248.
- `AMP`, 8'd64: per-channel waveform peak value.
- `clk` input 1: system clock (10 MHz).
- `n_rst` input 1: asynchronous, active-high reset; `n_rst`=1 resets all state.
- `keys` input 12: note request per channel; bit 0 = C … bit 11 = B; level-sensitive.
- `modekey` input 1: single-cycle pulse from keypad edge detector; toggles waveform mode.
- `sample_out` output 8: mixed, saturated sample for PWM.
- `sample_valid` output 1: one-cycle strobe; `sample_out` is new this cycle (drives PWM `start`).
- `active` output 12: key snapshot used for the current/last scan.
- `mode` output 1: 0 = square, 1 = sawtooth.
- `busy` output 1: high while scanning channels.

## Operation
- Divider table is an internal constant in semitone order: 38223, 36077, 34052, 32141, 30337, 28635, 27027, 25511, 24079, 22727, 21452, 20248.
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. `tick` fires when the count is SAMPLE_DIV-1.
- FSM states:
  - IDLE: waits for `tick`. On `tick`, snapshots `keys` into `active`, applies any pending mode toggle, clears the accumulator, sets ch=0, and goes to SCAN.
  - SCAN: processes one channel per clock and advances ch. After ch=11 it goes to DONE.
  - DONE: loads `sample_out` and pulses `sample_valid`. Returns to IDLE.
- Per-channel update in SCAN, with enabled channel `active[ch]`=1:
  - Compute a 17-bit sum s = count[ch] + SAMPLE_DIV.
  - If s >= div[ch]: count[ch] = s - div[ch] and level[ch] toggles. Otherwise count[ch] = s.
  - Waveform value: square gives AMP when level=1, else 0. Sawtooth gives {2'b00, count[15:10]} computed from the pre-update count.
  - accumulator (12-bit) += value.
- Per-channel update in SCAN, disabled channel: count[ch]=0, level[ch]=0, contributes 0. A note therefore always restarts from phase 0.
- Saturation: in DONE, `sample_out` = 255 if accumulator > 255, otherwise accumulator[7:0]. The accumulator cannot overflow 12 bits (12·255 max).
- `modekey` pulses set a pending-toggle flag. An odd number of pulses in one period toggles `mode` at the next scan start. Pulses arriving during SCAN apply at the following scan.
- `keys` changes during SCAN/DONE are ignored until the next snapshot.

## Timing
- Reset values: `sample_out`=0, `sample_valid`=0, `active`=0, `mode`=0, `busy`=0. Internally: FSM=IDLE, tick counter=0, all count=0, all level=0, pending toggle=0.
- First `tick` occurs SAMPLE_DIV-1 clocks after reset deassert.
- Tick at cycle T: snapshot at T, channels 0..11 processed at T+1..T+12, `sample_valid` high at T+13 only.
- `busy` is high during T+1..T+12.
- Scan plus output takes 14 cycles, which is less than SAMPLE_DIV, so no tick is missed. A tick that arrived while not IDLE could only occur with an illegal SAMPLE_DIV; it is ignored.
- `sample_out` holds its value between strobes.
- Reset mid-scan: all state returns to reset values immediately. No `sample_valid` is issued for the aborted scan.

## Configuration
- `NOTE_SAW_EN` defined: sawtooth mode is available and `modekey` toggles `mode`.
- `NOTE_SAW_EN` not defined: square only. `mode` is tied 0, `modekey` is ignored, and the sawtooth path and pending-toggle logic are not compiled.

## Test plan
- Reset mid-scan (assert `n_rst` at T+5) -> all outputs 0, no strobe. After release, the first strobe comes SAMPLE_DIV-1+13 clocks later.
- `keys`=12'h001 held, square -> `sample_out`=0 for strobes 1..149. Strobe 150 = 64 (level toggles, count residue 177). Stays 64 until the next toggle at tick 299.
- Force all levels high via 3 vs 4 keys in the high phase -> 3 keys give 192; 4 keys give 256, saturating to 255. 12 keys never exceed 255.
- Release C mid-tone, then re-press -> count[0]=0 and level[0]=0 after the release scan. The toggle recurs 150 ticks after the re-press snapshot.
- `NOTE_SAW_EN`: one `modekey` pulse -> `mode`=1 at the next tick. With C held, `sample_out` rises in steps to 37 max and wraps. Two pulses in one period -> `mode` unchanged.
- Change `keys` during `busy` -> the current strobe reflects the old snapshot. `active` updates only at the next tick.
